jtag_scan_chain: RTL and testbench
==================================

// Module: jtag_scan_chain
// PURPOSE
//  Data-path stage directly downstream of the TAP controller FSM: owns the IR and all DRs.
//  Consumes per-state strobes (capture/shift/update for IR and DR) plus TDI; drives TDO.
//  Replaces ad-hoc IDCODE streaming with a single IR-selected chain mux (IDCODE, BYPASS, USER).
// PARAMETERS
//  IR_WIDTH       4              instruction register width
//  IDCODE_VALUE   32'h000F_AF01  value captured into IDCODE DR (bit0 must be 1)
//  USER_WIDTH     8              width of USER data register
//  IR_CAPTURE     4'b0001        pattern loaded on capture_ir (LSBs 2'b01 per 1149.1)
// PORTS
//  clk             in   1           TCK; all state on posedge
//  reset           in   1           async active-high; clears all state immediately
//  enable          in   1           0 = hold all state, outputs idle
//  tdi             in   1           serial data in
//  test_logic_rst  in   1           TAP in Test-Logic-Reset
//  capture_ir      in   1           TAP in Capture-IR
//  shift_ir        in   1           TAP in Shift-IR
//  update_ir       in   1           TAP in Update-IR
//  capture_dr      in   1           TAP in Capture-DR
//  shift_dr        in   1           TAP in Shift-DR
//  update_dr       in   1           TAP in Update-DR
//  tdo             out  1           serial data out (combinational mux of register LSBs)
//  tdo_en          out  1           1 while shift_ir|shift_dr and enable
//  ir_value        out  IR_WIDTH    active instruction
//  user_dr_q       out  USER_WIDTH  USER register parallel output
//  user_dr_update  out  1           1-cycle pulse when user_dr_q loads
//  abort_pulse     out  1           1-cycle pulse on update_dr with IR=ABORT
// BEHAVIOUR
//  - Reset (async): ir_value=IDCODE(4'b1110), ir_shift=0, id_shift=0, bypass=0, user_shift=0,
//    user_dr_q=0, pulses=0, tdo=0, tdo_en=0.
//  - Opcodes: ABORT 4'b1000, USER 4'b1010, IDCODE 4'b1110, BYPASS 4'b1111; any other -> BYPASS.
//  - Strobes reflect current TAP state; action occurs on the posedge that leaves that state.
//  - Priority if >1 strobe high (illegal, must not hang): test_logic_rst > capture > shift > update.
//  - test_logic_rst: ir_value<=IDCODE next edge; shift regs untouched; user_dr_q held.
//  - capture_ir: ir_shift<=IR_CAPTURE. shift_ir: ir_shift<={tdi,ir_shift[W-1:1]}.
//  - update_ir: ir_value<=ir_shift (same edge; new IR visible next cycle).
//  - capture_dr by IR: IDCODE id_shift<=IDCODE_VALUE; USER user_shift<=user_dr_q; BYPASS bypass<=0.
//  - shift_dr: selected chain shifts right, tdi into MSB; BYPASS: bypass<=tdi (1-cycle delay).
//    Unselected chains hold.
//  - update_dr: USER -> user_dr_q<=user_shift, user_dr_update=1 for exactly next cycle;
//    ABORT -> abort_pulse=1 next cycle; IDCODE/BYPASS -> no effect.
//  - tdo: shift_ir -> ir_shift[0]; shift_dr -> LSB of selected chain; else 0.
//    First bit out = bit0 of captured value; latency TDI->TDO = chain length cycles.
//  - IDCODE chain is exactly 32 bits; shifting >32 cycles emits TDI delayed by 32 (no wrap).
//  - enable=0: no register updates, tdo=0, tdo_en=0, pulses forced 0.
//  - Reset mid-shift: partial data discarded; first posedge after release behaves as post-reset.
// STRUCTURE
//  - jtag_pkg: opcode localparams, IR_WIDTH default, IR_CAPTURE default.
//  - Sub-module jtag_shift_reg #(WIDTH): capture(load value), shift(tdi in MSB), q, so=q[0];
//    instantiated for IR, IDCODE, USER. Bypass is a single flop in this module.
//  - Top: strobe priority decode, IR-driven chain select, TDO mux, update pulses.
// TESTING
//  1 Reset, capture_dr, 32x shift_dr (IR default) -> tdo bits = 32'h000FAF01 LSB first.
//  2 capture_ir, 4x shift_ir tdi=1 -> tdo 1,0,0,0; update_ir -> ir_value=4'hF next cycle.
//  3 IR=BYPASS, capture_dr, shift tdi 1,0,1,1,0 -> tdo 0,1,0,1,1.
//  4 IR=USER, shift 8'hA5 LSB first, update_dr -> user_dr_q=8'hA5, user_dr_update high 1 cycle;
//    re-capture/shift -> tdo = A5 LSB first.
//  5 IR=4'b0000, capture_dr+shift -> behaves as BYPASS; IR=ABORT, update_dr -> abort_pulse 1 cycle.
//  6 Reset mid IDCODE shift (bit 10) -> tdo=0, ir_value=4'b1110 at once; test_logic_rst with
//    IR=USER -> ir_value=4'b1110, user_dr_q unchanged; enable=0 during shift -> state frozen.

Source files
------------

// File: rtl/jtag_scan_chain_pkg.sv
// jtag_scan_chain_pkg: opcodes, IR defaults and chain-select type shared by the scan chain files.
package jtag_scan_chain_pkg;
  localparam int DEFAULT_IR_WIDTH = 4;
  localparam logic [DEFAULT_IR_WIDTH-1:0] DEFAULT_IR_CAPTURE = 4'b0001;
  localparam logic [DEFAULT_IR_WIDTH-1:0] OP_ABORT = 4'b1000;
  localparam logic [DEFAULT_IR_WIDTH-1:0] OP_USER = 4'b1010;
  localparam logic [DEFAULT_IR_WIDTH-1:0] OP_IDCODE = 4'b1110;
  localparam logic [DEFAULT_IR_WIDTH-1:0] OP_BYPASS = 4'b1111;
  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_USER} chain_sel_e;
endpackage

// File: rtl/jtag_scan_chain_shift_reg.sv
// jtag_scan_chain_shift_reg: parallel-capture, right-shift register with serial input in the MSB.
module jtag_scan_chain_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             shift,
  input  logic             si,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             so
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (capture) q <= din;
    else if (shift) q <= {si, q[WIDTH-1:1]};
  assign so = q[0];
endmodule

// File: rtl/jtag_scan_chain.sv
// jtag_scan_chain: IR plus IDCODE/BYPASS/USER data registers behind the TAP controller, with TDO mux.
module jtag_scan_chain
  import jtag_scan_chain_pkg::*;
#(
  parameter int                    IR_WIDTH     = DEFAULT_IR_WIDTH,
  parameter logic [31:0]           IDCODE_VALUE = 32'h000F_AF01,
  parameter int                    USER_WIDTH   = 8,
  parameter logic [IR_WIDTH-1:0]   IR_CAPTURE   = IR_WIDTH'(DEFAULT_IR_CAPTURE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  tdi,
  input  logic                  test_logic_rst,
  input  logic                  capture_ir,
  input  logic                  shift_ir,
  input  logic                  update_ir,
  input  logic                  capture_dr,
  input  logic                  shift_dr,
  input  logic                  update_dr,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [IR_WIDTH-1:0]   ir_value,
  output logic [USER_WIDTH-1:0] user_dr_q,
  output logic                  user_dr_update,
  output logic                  abort_pulse
);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_USER = IR_WIDTH'(OP_USER);
  localparam logic [IR_WIDTH-1:0] IR_ABORT = IR_WIDTH'(OP_ABORT);
  logic go, any_cap, any_sh;
  logic cap_ir, cap_dr, sh_ir, sh_dr, upd_ir, upd_dr;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0] id_shift;
  logic [USER_WIDTH-1:0] user_shift;
  logic ir_so, id_so, user_so, dr_so, bypass;
  logic user_upd_q, abort_q;
  logic unused_id_bits;
  chain_sel_e sel;
  // Illegal strobe overlaps resolve as test_logic_rst > capture > shift > update.
  assign go = enable & ~test_logic_rst;
  assign any_cap = capture_ir | capture_dr;
  assign any_sh = shift_ir | shift_dr;
  assign cap_ir = go & capture_ir;
  assign cap_dr = go & capture_dr & ~capture_ir;
  assign sh_ir = go & ~any_cap & shift_ir;
  assign sh_dr = go & ~any_cap & shift_dr & ~shift_ir;
  assign upd_ir = go & ~any_cap & ~any_sh & update_ir;
  assign upd_dr = go & ~any_cap & ~any_sh & update_dr & ~update_ir;
  assign sel = (ir_value == IR_USER) ? SEL_USER : (ir_value == IR_IDCODE) ? SEL_IDCODE : SEL_BYPASS;
  jtag_scan_chain_shift_reg #(.WIDTH(IR_WIDTH)) u_ir (
    .clk(clk), .reset(reset), .capture(cap_ir), .shift(sh_ir), .si(tdi),
    .din(IR_CAPTURE), .q(ir_shift), .so(ir_so)
  );
  jtag_scan_chain_shift_reg #(.WIDTH(32)) u_idcode (
    .clk(clk), .reset(reset), .capture(cap_dr & (sel == SEL_IDCODE)),
    .shift(sh_dr & (sel == SEL_IDCODE)), .si(tdi),
    .din(IDCODE_VALUE), .q(id_shift), .so(id_so)
  );
  jtag_scan_chain_shift_reg #(.WIDTH(USER_WIDTH)) u_user (
    .clk(clk), .reset(reset), .capture(cap_dr & (sel == SEL_USER)),
    .shift(sh_dr & (sel == SEL_USER)), .si(tdi),
    .din(user_dr_q), .q(user_shift), .so(user_so)
  );
  assign unused_id_bits = ^id_shift[31:1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ir_value <= IR_IDCODE;
      user_dr_q <= '0;
      bypass <= 1'b0;
      user_upd_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      user_upd_q <= upd_dr & (sel == SEL_USER);
      abort_q <= upd_dr & (ir_value == IR_ABORT);
      if (enable & test_logic_rst) ir_value <= IR_IDCODE;
      else if (upd_ir) ir_value <= ir_shift;
      if (upd_dr & (sel == SEL_USER)) user_dr_q <= user_shift;
      if ((sel == SEL_BYPASS) & (cap_dr | sh_dr)) bypass <= sh_dr & tdi;
    end
  assign dr_so = (sel == SEL_USER) ? user_so : (sel == SEL_IDCODE) ? id_so : bypass;
  assign tdo = ~reset & (sh_ir ? ir_so : sh_dr ? dr_so : 1'b0);
  assign tdo_en = ~reset & enable & any_sh;
  assign user_dr_update = user_upd_q & enable;
  assign abort_pulse = abort_q & enable;
endmodule

// File: tb/tb_jtag_scan_chain.sv
// tb_jtag_scan_chain: directed scenarios plus random strobe sequences checked against a queue-based model.
module tb_jtag_scan_chain;
  localparam logic [6:0] S_NONE = 7'b0000000, S_TLR = 7'b1000000, S_CIR = 7'b0100000, S_SIR = 7'b0010000;
  localparam logic [6:0] S_UIR = 7'b0001000, S_CDR = 7'b0000100, S_SDR = 7'b0000010, S_UDR = 7'b0000001;
  localparam logic [31:0] IDV = 32'h000F_AF01;
  localparam logic [3:0] ABORT = 4'b1000, USER = 4'b1010, IDCODE = 4'b1110, BYPASS = 4'b1111;
  typedef bit bq_t[$];
  logic clk = 1'b0, reset, enable, tdi;
  logic tlr, cir, sir, uir, cdr, sdr, udr;
  logic tdo, tdo_en, user_dr_update, abort_pulse;
  logic [3:0] ir_value;
  logic [7:0] user_dr_q;
  int n_cmp = 0, n_err = 0;
  logic [3:0] m_ir;
  bq_t m_irq, m_idq, m_usq;
  logic m_byp, m_uup, m_abp;
  logic [7:0] m_uq;

  jtag_scan_chain dut (
    .clk(clk), .reset(reset), .enable(enable), .tdi(tdi), .test_logic_rst(tlr),
    .capture_ir(cir), .shift_ir(sir), .update_ir(uir), .capture_dr(cdr), .shift_dr(sdr),
    .update_dr(udr), .tdo(tdo), .tdo_en(tdo_en), .ir_value(ir_value), .user_dr_q(user_dr_q),
    .user_dr_update(user_dr_update), .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  function automatic bq_t mkq(input logic [31:0] v, input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(v[i]);
    return q;
  endfunction

  function automatic logic [31:0] packq(input bq_t q);
    logic [31:0] r = '0;
    for (int i = 0; i < q.size(); i++) r[i] = q[i];
    return r;
  endfunction

  function automatic int msel();
    return (m_ir == USER) ? 2 : (m_ir == IDCODE) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_ir = IDCODE; m_irq = mkq(0, 4); m_idq = mkq(0, 32); m_usq = mkq(0, 8);
    m_byp = 0; m_uq = 0; m_uup = 0; m_abp = 0;
  endtask

  function automatic logic model_tdo();
    if (reset || !enable || tlr || cir || cdr) return 1'b0;
    if (sir) return m_irq[0];
    if (sdr) return (msel() == 2) ? m_usq[0] : (msel() == 1) ? m_idq[0] : m_byp;
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [31:0] p;
    m_uup = 0; m_abp = 0;
    if (!enable) return;
    if (tlr) m_ir = IDCODE;
    else if (cir) m_irq = mkq(32'b0001, 4);
    else if (cdr) begin
      if (msel() == 2) m_usq = mkq({24'b0, m_uq}, 8);
      else if (msel() == 1) m_idq = mkq(IDV, 32);
      else m_byp = 0;
    end else if (sir) begin
      void'(m_irq.pop_front()); m_irq.push_back(tdi);
    end else if (sdr) begin
      if (msel() == 2) begin void'(m_usq.pop_front()); m_usq.push_back(tdi); end
      else if (msel() == 1) begin void'(m_idq.pop_front()); m_idq.push_back(tdi); end
      else m_byp = tdi;
    end else if (uir) begin
      p = packq(m_irq); m_ir = p[3:0];
    end else if (udr) begin
      if (msel() == 2) begin p = packq(m_usq); m_uq = p[7:0]; m_uup = 1; end
      if (m_ir == ABORT) m_abp = 1;
    end
  endtask

  task automatic cyc(input logic [6:0] s, input logic d, output logic t, output logic te, output logic mt);
    {tlr, cir, sir, uir, cdr, sdr, udr} = s; tdi = d;
    #1; t = tdo; te = tdo_en; mt = model_tdo();
    @(posedge clk); model_step(); #1;
  endtask

  task automatic load_ir(input logic [3:0] op);
    logic t, te, mt;
    cyc(S_CIR, 0, t, te, mt);
    for (int i = 0; i < 4; i++) cyc(S_SIR, op[i], t, te, mt);
    cyc(S_UIR, 0, t, te, mt);
    cyc(S_NONE, 0, t, te, mt);
  endtask

  task automatic test_reset();
    enable = 1; reset = 1; {tlr, cir, sir, uir, cdr, udr} = '0; sdr = 1; tdi = 1;
    model_reset(); #1;
    n_cmp++; if (tdo !== 1'b0) begin n_err++; $display("FAIL reset_tdo: got %b want 0", tdo); end
    n_cmp++; if (tdo_en !== 1'b0) begin n_err++; $display("FAIL reset_tdo_en: got %b want 0", tdo_en); end
    n_cmp++; if (ir_value !== IDCODE) begin n_err++; $display("FAIL reset_ir: got %h want %h", ir_value, IDCODE); end
    n_cmp++; if (user_dr_q !== 8'h00) begin n_err++; $display("FAIL reset_user_q: got %h want 00", user_dr_q); end
    n_cmp++; if ({user_dr_update, abort_pulse} !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got %b want 00", {user_dr_update, abort_pulse}); end
    @(posedge clk); #1; reset = 0; sdr = 0; tdi = 0;
  endtask

  task automatic test_idcode();
    logic t, te, mt;
    logic [39:0] d = {$urandom, $urandom};
    logic [31:0] v;
    cyc(S_CDR, 0, t, te, mt);
    for (int i = 0; i < 40; i++) begin
      cyc(S_SDR, d[i], t, te, mt);
      if (i < 32) v[i] = t;
      else begin
        n_cmp++; if (t !== d[i-32]) begin n_err++; $display("FAIL idcode_overrun bit %0d: got %b want %b", i, t, d[i-32]); end
      end
    end
    n_cmp++; if (v !== IDV) begin n_err++; $display("FAIL idcode_scan: got %h want %h", v, IDV); end
  endtask

  task automatic test_ir_scan();
    logic t, te, mt;
    logic [3:0] v;
    cyc(S_CIR, 0, t, te, mt);
    for (int i = 0; i < 4; i++) begin
      cyc(S_SIR, 1, t, te, mt); v[i] = t;
      if (i == 0) begin
        n_cmp++; if (te !== 1'b1) begin n_err++; $display("FAIL ir_tdo_en: got %b want 1", te); end
      end
    end
    n_cmp++; if (v !== 4'b0001) begin n_err++; $display("FAIL ir_capture_out: got %b want 0001", v); end
    cyc(S_UIR, 0, t, te, mt);
    n_cmp++; if (ir_value !== 4'hF) begin n_err++; $display("FAIL ir_update: got %h want f", ir_value); end
  endtask

  task automatic test_bypass(input logic [3:0] op);
    logic t, te, mt;
    logic [4:0] d = 5'b01101, v;
    load_ir(op);
    n_cmp++; if (ir_value !== op) begin n_err++; $display("FAIL bypass_ir: got %h want %h", ir_value, op); end
    cyc(S_CDR, 0, t, te, mt);
    for (int i = 0; i < 5; i++) begin cyc(S_SDR, d[i], t, te, mt); v[i] = t; end
    n_cmp++; if (v !== 5'b11010) begin n_err++; $display("FAIL bypass_out ir=%h: got %b want 11010", op, v); end
  endtask

  task automatic test_user();
    logic t, te, mt;
    logic [7:0] d = 8'hA5, v;
    load_ir(USER);
    cyc(S_CDR, 0, t, te, mt);
    for (int i = 0; i < 8; i++) cyc(S_SDR, d[i], t, te, mt);
    cyc(S_UDR, 0, t, te, mt);
    n_cmp++; if (user_dr_q !== 8'hA5) begin n_err++; $display("FAIL user_q: got %h want a5", user_dr_q); end
    n_cmp++; if (user_dr_update !== 1'b1) begin n_err++; $display("FAIL user_pulse_on: got %b want 1", user_dr_update); end
    cyc(S_NONE, 0, t, te, mt);
    n_cmp++; if (user_dr_update !== 1'b0) begin n_err++; $display("FAIL user_pulse_off: got %b want 0", user_dr_update); end
    cyc(S_CDR, 0, t, te, mt);
    for (int i = 0; i < 8; i++) begin cyc(S_SDR, 0, t, te, mt); v[i] = t; end
    n_cmp++; if (v !== 8'hA5) begin n_err++; $display("FAIL user_recapture: got %h want a5", v); end
  endtask

  task automatic test_abort();
    logic t, te, mt;
    load_ir(ABORT);
    cyc(S_UDR, 0, t, te, mt);
    n_cmp++; if ({abort_pulse, user_dr_update} !== 2'b10) begin n_err++; $display("FAIL abort_on: got %b want 10", {abort_pulse, user_dr_update}); end
    cyc(S_NONE, 0, t, te, mt);
    n_cmp++; if (abort_pulse !== 1'b0) begin n_err++; $display("FAIL abort_off: got %b want 0", abort_pulse); end
  endtask

  task automatic test_reset_mid();
    logic t, te, mt;
    logic [31:0] v;
    load_ir(IDCODE);
    cyc(S_CDR, 0, t, te, mt);
    for (int i = 0; i < 10; i++) cyc(S_SDR, 1, t, te, mt);
    reset = 1; #1;
    n_cmp++; if (tdo !== 1'b0) begin n_err++; $display("FAIL midreset_tdo: got %b want 0", tdo); end
    n_cmp++; if (ir_value !== IDCODE) begin n_err++; $display("FAIL midreset_ir: got %h want e", ir_value); end
    model_reset();
    @(posedge clk); #1; reset = 0;
    cyc(S_CDR, 0, t, te, mt);
    for (int i = 0; i < 32; i++) begin cyc(S_SDR, 0, t, te, mt); v[i] = t; end
    n_cmp++; if (v !== IDV) begin n_err++; $display("FAIL midreset_rescan: got %h want %h", v, IDV); end
  endtask

  task automatic test_tlr();
    logic t, te, mt;
    logic [7:0] d = 8'h3C;
    load_ir(USER);
    cyc(S_CDR, 0, t, te, mt);
    for (int i = 0; i < 8; i++) cyc(S_SDR, d[i], t, te, mt);
    cyc(S_UDR, 0, t, te, mt);
    cyc(S_TLR, 0, t, te, mt);
    n_cmp++; if (ir_value !== IDCODE) begin n_err++; $display("FAIL tlr_ir: got %h want e", ir_value); end
    n_cmp++; if (user_dr_q !== 8'h3C) begin n_err++; $display("FAIL tlr_user_q: got %h want 3c", user_dr_q); end
  endtask

  task automatic test_enable();
    logic t, te, mt;
    logic [31:0] v;
    cyc(S_CDR, 0, t, te, mt);
    for (int i = 0; i < 5; i++) begin cyc(S_SDR, 0, t, te, mt); v[i] = t; end
    enable = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(S_SDR, 1'($urandom), t, te, mt);
      n_cmp++; if ({t, te} !== 2'b00) begin n_err++; $display("FAIL disabled_tdo: got %b want 00", {t, te}); end
    end
    cyc(S_UIR, 0, t, te, mt);
    n_cmp++; if (ir_value !== IDCODE) begin n_err++; $display("FAIL disabled_ir: got %h want e", ir_value); end
    enable = 1;
    for (int i = 5; i < 32; i++) begin cyc(S_SDR, 0, t, te, mt); v[i] = t; end
    n_cmp++; if (v !== IDV) begin n_err++; $display("FAIL enable_resume: got %h want %h", v, IDV); end
  endtask

  task automatic test_random();
    logic t, te, mt;
    logic [6:0] picks [10] = '{S_NONE, S_TLR, S_CIR, S_SIR, S_UIR, S_CDR, S_SDR, S_SDR, S_SDR, S_UDR};
    logic [3:0] ops [5];
    for (int k = 0; k < 16; k++) begin
      ops = '{ABORT, USER, IDCODE, BYPASS, 4'($urandom)};
      enable = 1;
      load_ir(ops[$urandom_range(0, 4)]);
      for (int i = 0; i < 25; i++) begin
        enable = ($urandom_range(0, 9) != 0);
        cyc(picks[$urandom_range(0, 9)], 1'($urandom), t, te, mt);
        n_cmp++; if (t !== mt) begin n_err++; $display("FAIL rand_tdo seq %0d cyc %0d: got %b want %b", k, i, t, mt); end
        n_cmp++; if (ir_value !== m_ir) begin n_err++; $display("FAIL rand_ir: got %h want %h", ir_value, m_ir); end
        n_cmp++; if (user_dr_q !== m_uq) begin n_err++; $display("FAIL rand_user_q: got %h want %h", user_dr_q, m_uq); end
        n_cmp++; if ({user_dr_update, abort_pulse} !== {m_uup & enable, m_abp & enable}) begin
          n_err++; $display("FAIL rand_pulses: got %b want %b", {user_dr_update, abort_pulse}, {m_uup & enable, m_abp & enable});
        end
      end
    end
    enable = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idcode();
    test_ir_scan();
    test_bypass(BYPASS);
    test_user();
    test_bypass(4'b0000);
    test_abort();
    test_reset_mid();
    test_tlr();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
